// File: rtl/shat_mac_sched_if.sv
// Sample, coefficient-write and result signals of shat_mac_sched.
// The master drives samples and coefficients; the slave (the filter) returns results.
interface shat_mac_sched_if #(
    parameter int N     = 32,
    parameter int IN_W  = 32,
    parameter int SH_W  = 32,
    parameter int OUT_W = 32
);
    localparam int TW = $clog2(N);

    logic                    valid_in;
    logic signed [IN_W-1:0]  data_in;
    logic                    coef_we;
    logic [TW-1:0]           coef_waddr;
    logic signed [SH_W-1:0]  coef_wdata;
    logic signed [OUT_W-1:0] data_out;
    logic                    valid_out;
    logic                    busy;
    logic                    overrun;

    modport master (
        output valid_in, data_in, coef_we, coef_waddr, coef_wdata,
        input  data_out, valid_out, busy, overrun
    );

    modport slave (
        input  valid_in, data_in, coef_we, coef_waddr, coef_wdata,
        output data_out, valid_out, busy, overrun
    );
endinterface

// File: rtl/shat_mac_sched.sv
// Time-multiplexed N-tap FIR: one signed multiplier and one accumulator step through the taps.
// A result appears N cycles after a sample is captured; samples arriving mid-convolution are
// dropped and flagged on a sticky overrun bit.
// Optional feature: define SHAT_SAT_EN to clamp the rounded result to the OUT_W signed range;
// without it the result wraps (low OUT_W bits).
module shat_mac_sched #(
    parameter int N     = 32,
    parameter int IN_W  = 32,
    parameter int SH_W  = 32,
    parameter int OUT_W = 32,
    parameter int R_IN  = 31,
    parameter int R_SH  = 30,
    parameter int R_OUT = 31
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    shat_mac_sched_if.slave       bus
);
    localparam int TW = $clog2(N);
    localparam int PW = IN_W + SH_W;
    localparam int AW = IN_W + SH_W + TW;
    localparam int S  = R_IN + R_SH - R_OUT;

    localparam logic signed [AW:0]      RND_HALF = (AW+1)'(1) << (S - 1);
    localparam logic signed [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StRound} state_t;

    state_t                  r_state, w_state_next;
    logic [TW-1:0]           r_tap;
    logic [TW-1:0]           r_wptr;
    logic [TW-1:0]           r_base;
    logic signed [AW-1:0]    r_acc;
    logic signed [IN_W-1:0]  r_dline [N];
    logic signed [SH_W-1:0]  r_coef  [N];
    logic signed [OUT_W-1:0] r_data_out;
    logic                    r_valid_out;
    logic                    r_overrun;

    logic                    w_capture;
    logic [TW-1:0]           w_rd_idx;
    logic signed [IN_W-1:0]  w_mul_a;
    logic signed [SH_W-1:0]  w_mul_b;
    logic signed [PW-1:0]    w_prod;
    logic signed [AW-1:0]    w_prod_ext;
    logic signed [AW:0]      w_sum;
    logic signed [OUT_W-1:0] w_result;

    // A sample is taken from IDLE, or from ROUND so back-to-back samples N cycles apart chain.
    assign w_capture = bus.valid_in && (r_state == StIdle || r_state == StRound);

    // Shared multiplier: the capture edge uses the incoming sample with h[0], MAC uses history.
    always_comb begin
        w_rd_idx   = r_base - r_tap;
        w_mul_a    = bus.data_in;
        w_mul_b    = r_coef[0];
        if (r_state == StMac) begin
            w_mul_a = r_dline[w_rd_idx];
            w_mul_b = r_coef[r_tap];
        end
        w_prod     = w_mul_a * w_mul_b;
        w_prod_ext = {{TW{w_prod[PW-1]}}, w_prod};
    end

    // Round half up, then clamp or wrap into OUT_W.
    always_comb begin
        logic signed [AW:0] w_shift;
        w_sum   = $signed({r_acc[AW-1], r_acc}) + RND_HALF;
        w_shift = w_sum >>> S;
`ifdef SHAT_SAT_EN
        if ((&w_shift[AW:OUT_W-1]) || !(|w_shift[AW:OUT_W-1])) begin
            w_result = w_shift[OUT_W-1:0];
        end else if (w_shift[AW]) begin
            w_result = OUT_MIN;
        end else begin
            w_result = OUT_MAX;
        end
`else
        w_result = OUT_W'(w_shift);
`endif
    end

    // Next-state logic: MAC runs taps 1..N-1, then one ROUND cycle registers the result.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.valid_in) w_state_next = StMac;
            StMac:   if (r_tap == TW'(N - 1)) w_state_next = StRound;
            StRound: w_state_next = bus.valid_in ? StMac : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register, tap counter, delay line and accumulator.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_tap   <= '0;
            r_wptr  <= '0;
            r_base  <= '0;
            r_acc   <= '0;
            for (int i = 0; i < N; i++) r_dline[i] <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_dline[r_wptr] <= bus.data_in;
                r_base          <= r_wptr;
                r_wptr          <= r_wptr + TW'(1);
                r_acc           <= w_prod_ext;
                r_tap           <= TW'(1);
            end else if (r_state == StMac) begin
                r_acc <= r_acc + w_prod_ext;
                r_tap <= r_tap + TW'(1);
            end
        end
    end

    // Coefficient bank: writable only while idle so a running convolution sees stable taps.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < N; i++) r_coef[i] <= '0;
        end else if (bus.coef_we && r_state == StIdle) begin
            r_coef[bus.coef_waddr] <= bus.coef_wdata;
        end
    end

    // Result register, one-cycle valid strobe and sticky overrun flag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_valid_out <= (r_state == StRound);
            if (r_state == StRound) r_data_out <= w_result;
            if (r_state == StMac && bus.valid_in) r_overrun <= 1'b1;
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.busy      = (r_state != StIdle);
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_shat_mac_sched.sv
// Directed bench for shat_mac_sched with default parameters (N=32, Q1.31 in/out, Q2.30 coefs).
module tb_shat_mac_sched;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;
    int   pulses;

    always #5 clk = ~clk;

    shat_mac_sched_if bus ();

    shat_mac_sched dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wr_coef(input logic [4:0] addr, input logic [31:0] data);
        bus.coef_we    = 1'b1;
        bus.coef_waddr = addr;
        bus.coef_wdata = data;
        tick();
        bus.coef_we    = 1'b0;
    endtask

    task automatic send(input logic [31:0] data);
        bus.valid_in = 1'b1;
        bus.data_in  = data;
        tick();
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
    endtask

    // Cycles after the current edge until valid_out is seen; -1 on timeout.
    task automatic wait_out(output int c);
        c = -1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (bus.valid_out) begin
                c = k;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int len, output int p);
        p = 0;
        for (int k = 0; k < len; k++) begin
            tick();
            if (bus.valid_out) p++;
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] din, input logic [31:0] exp);
        int c;
        send(din);
        wait_out(c);
        check({tag, "_lat"}, c, 32);
        check(tag, bus.data_out, exp);
    endtask

    initial begin
        rst            = 1'b1;
        bus.valid_in   = 1'b0;
        bus.data_in    = '0;
        bus.coef_we    = 1'b0;
        bus.coef_waddr = '0;
        bus.coef_wdata = '0;

        // Reset state
        do_reset();
        check("rst_data_out", bus.data_out, 32'h0);
        check("rst_valid_out", {31'b0, bus.valid_out}, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_overrun", {31'b0, bus.overrun}, 32'h0);

        // Unit impulse through h[0]=1.0, latency exactly 32 cycles, single-cycle strobe
        wr_coef(5'd0, 32'h4000_0000);
        send(32'h4000_0000);
        check("imp_busy", {31'b0, bus.busy}, 32'h1);
        wait_out(cyc);
        check("imp_lat", cyc, 32);
        check("imp_data", bus.data_out, 32'h4000_0000);
        tick();
        check("imp_strobe", {31'b0, bus.valid_out}, 32'h0);
        check("imp_idle", {31'b0, bus.busy}, 32'h0);
        check("imp_hold", bus.data_out, 32'h4000_0000);

        // Round half up with h[0] = 1 LSB: 0.5->1, -0.5->0, 1.5->2, -1.5->-1
        do_reset();
        wr_coef(5'd0, 32'h0000_0001);
        run_one("rnd_p05", 32'h2000_0000, 32'h0000_0001);
        run_one("rnd_m05", 32'hE000_0000, 32'h0000_0000);
        run_one("rnd_p15", 32'h6000_0000, 32'h0000_0002);
        run_one("rnd_m15", 32'hA000_0000, 32'hFFFF_FFFF);

        // Delayed tap h[3]: impulse then zeros
        do_reset();
        wr_coef(5'd3, 32'h4000_0000);
        run_one("d3_y0", 32'h2000_0000, 32'h0);
        run_one("d3_y1", 32'h0, 32'h0);
        run_one("d3_y2", 32'h0, 32'h0);
        run_one("d3_y3", 32'h0, 32'h2000_0000);
        run_one("d3_y4", 32'h0, 32'h0);

        // Interval 32: second sample accepted in ROUND
        do_reset();
        wr_coef(5'd0, 32'h4000_0000);
        wr_coef(5'd1, 32'h4000_0000);
        send(32'h1000_0000);
        repeat (31) tick();
        send(32'h0800_0000);
        check("i32_valid_a", {31'b0, bus.valid_out}, 32'h1);
        check("i32_data_a", bus.data_out, 32'h1000_0000);
        check("i32_busy_b", {31'b0, bus.busy}, 32'h1);
        wait_out(cyc);
        check("i32_lat_b", cyc, 32);
        check("i32_data_b", bus.data_out, 32'h1800_0000);
        check("i32_overrun", {31'b0, bus.overrun}, 32'h0);

        // Interval 31: second sample dropped, sticky overrun until reset
        do_reset();
        wr_coef(5'd0, 32'h4000_0000);
        send(32'h1000_0000);
        repeat (30) tick();
        send(32'h0800_0000);
        check("i31_overrun", {31'b0, bus.overrun}, 32'h1);
        wait_out(cyc);
        check("i31_lat_a", cyc, 1);
        check("i31_data_a", bus.data_out, 32'h1000_0000);
        count_pulses(40, pulses);
        check("i31_dropped", pulses, 0);
        check("i31_sticky", {31'b0, bus.overrun}, 32'h1);
        do_reset();
        check("i31_clr", {31'b0, bus.overrun}, 32'h0);

        // All taps 1.0, max positive input repeated
        do_reset();
        for (int i = 0; i < 32; i++) wr_coef(5'(i), 32'h4000_0000);
        run_one("sat_y0", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
`ifdef SHAT_SAT_EN
        run_one("sat_y1", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_one("sat_y2", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
`else
        run_one("wrap_y1", 32'h7FFF_FFFF, 32'hFFFF_FFFE);
        run_one("wrap_y2", 32'h7FFF_FFFF, 32'h7FFF_FFFD);
`endif

        // Reset at tap 10 abandons the convolution and clears history
        do_reset();
        wr_coef(5'd0, 32'h4000_0000);
        wr_coef(5'd1, 32'h4000_0000);
        send(32'h4000_0000);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", {31'b0, bus.busy}, 32'h0);
        check("mrst_data", bus.data_out, 32'h0);
        count_pulses(40, pulses);
        check("mrst_no_valid", pulses, 0);
        wr_coef(5'd0, 32'h4000_0000);
        wr_coef(5'd1, 32'h4000_0000);
        run_one("mrst_hist", 32'h1000_0000, 32'h1000_0000);

        // Coefficient write while busy is ignored
        do_reset();
        wr_coef(5'd0, 32'h7FFF_FFFF);
        send(32'h4000_0000);
        repeat (3) tick();
        wr_coef(5'd0, 32'h4000_0000);
        wait_out(cyc);
        check("cwb_found", {31'b0, cyc > 0}, 32'h1);
        check("cwb_data", bus.data_out, 32'h7FFF_FFFF);
        check("cwb_overrun", {31'b0, bus.overrun}, 32'h0);
        run_one("cwb_next", 32'h2000_0000, 32'h4000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
